// File: rtl/niosii_system_sysid_ext.sv
// System-ID slave with scratch register and coherent uptime counter.
// Avalon-MM, one-cycle registered reads, always ready.
module niosii_system_sysid_ext #(
  parameter logic [31:0] ID_VALUE     = 32'h5899_8DEB,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          COUNT_WIDTH  = 64,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int HW = COUNT_WIDTH - 32;

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [HW-1:0]          hi_q, hi_d;
  logic [31:0]            scratch_q, scratch_d;
  logic                   freeze_q, freeze_d;
  logic                   wrap_q, wrap_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;

  logic wr_en, clr, wr_lo, wr_hi;

  always_comb begin
    wr_en = write & ~read;
    clr   = wr_en && address == 3'd5 && writedata[0];
    wr_lo = wr_en && address == 3'd3;
    wr_hi = wr_en && address == 3'd4;

    cnt_d     = cnt_q;
    hi_d      = hi_q;
    scratch_d = scratch_q;
    freeze_d  = freeze_q;
    wrap_d    = wrap_q;
    rdata_d   = rdata_q;
    rvalid_d  = read;

    if (read) begin
      unique case (address)
        3'd0: rdata_d = ID_VALUE;
        3'd1: rdata_d = TIMESTAMP;
        3'd2: rdata_d = scratch_q;
        3'd3: begin
          rdata_d = cnt_q[31:0];
          hi_d    = cnt_q[COUNT_WIDTH-1:32];
        end
        3'd4: rdata_d = 32'(hi_q);
        3'd5: rdata_d = {30'd0, freeze_q, 1'b0};
        3'd6: rdata_d = {31'd0, wrap_q};
        default: rdata_d = 32'd0;
      endcase
    end

    if (wr_en) begin
      unique case (address)
        3'd2: begin
          for (int b = 0; b < 4; b++)
            if (byteenable[b])
              scratch_d[8*b +: 8] = writedata[8*b +: 8];
        end
        3'd4: hi_d = writedata[HW-1:0];
        3'd5: freeze_d = writedata[1];
        3'd6: if (writedata[0]) wrap_d = 1'b0;
        default: ;
      endcase
    end

    // A wrap in the same cycle as a W1C keeps the flag set.
    if (clr)
      cnt_d = '0;
    else if (wr_lo)
      cnt_d[31:0] = writedata;
    else if (wr_hi)
      cnt_d[COUNT_WIDTH-1:32] = writedata[HW-1:0];
    else if (!freeze_q) begin
      cnt_d = cnt_q + COUNT_WIDTH'(1);
      if (&cnt_q) wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      scratch_q <= SCRATCH_INIT;
      freeze_q  <= 1'b0;
      wrap_q    <= 1'b0;
      rdata_q   <= 32'd0;
      rvalid_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      scratch_q <= scratch_d;
      freeze_q  <= freeze_d;
      wrap_q    <= wrap_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: doc/niosii_system_sysid_ext.md
# niosII_system_sysid_ext

Parametrised successor to the Qsys system-ID slave. It is an Avalon-MM slave on the Nios II data master exposing:
- a read-only system ID and build timestamp;
- a software scratch register;
- a free-running uptime counter with coherent 64-bit snapshot, freeze, clear, preload and a sticky wrap flag.

Reads are registered with one-cycle latency.

## Interface
Parameters:
- ID_VALUE, 32'h5899_8DEB, value returned at word 0
- TIMESTAMP, 32'h0000_0000, build timestamp returned at word 1
- COUNT_WIDTH, 64, uptime counter width, legal 33..64; unused HI bits read 0
- SCRATCH_INIT, 32'h0000_0000, reset value of SCRATCH

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- read  in  1  read strobe, one cycle per transfer
- write  in  1  write strobe, one cycle per transfer
- writedata  in  32  write data
- byteenable  in  4  write byte lanes; SCRATCH only, other registers use full word
- readdata  out  32  registered read data
- readdatavalid  out  1  one-cycle pulse, readdata valid

## Operation
Register map:
- 0 ID: RO, returns ID_VALUE
- 1 TIMESTAMP: RO, returns TIMESTAMP
- 2 SCRATCH: RW, byte-enabled
- 3 UPTIME_LO: read returns cnt[31:0] and in the same cycle latches cnt[COUNT_WIDTH-1:32] into HI_SHADOW; write preloads cnt[31:0]
- 4 UPTIME_HI: read returns HI_SHADOW, zero-extended; write preloads cnt[COUNT_WIDTH-1:32] and HI_SHADOW
- 5 CONTROL: bit0 CLEAR, write-1 pulse, reads 0; bit1 FREEZE, RW; other bits 0
- 6 STATUS: bit0 WRAPPED, sticky, write-1-to-clear
- 7: reads 0, writes ignored

Counter update, per cycle, highest priority first:
1. CLEAR write: cnt <= 0.
2. Preload write (address 3/4): the written field is loaded; the other field holds, with no increment that cycle.
3. FREEZE=1: cnt holds.
4. Otherwise cnt <= cnt+1, modulo 2^COUNT_WIDTH. On the all-ones to 0 transition, WRAPPED <= 1.

Write and bus rules:
- A CLEAR write with bit1 also set applies both: cnt <= 0 and FREEZE <= 1.
- A STATUS W1C write in the same cycle as a wrap leaves WRAPPED = 1 (set wins).
- read and write asserted in the same cycle: read is served, write is dropped.

Reset values (all outputs and state):
- readdata = 0, readdatavalid = 0
- SCRATCH = SCRATCH_INIT
- cnt = 0, HI_SHADOW = 0, FREEZE = 0, WRAPPED = 0

Reset mid-operation:
- Asynchronous assertion clears all state immediately.
- A read in flight is lost: no readdatavalid is issued.
- The counter restarts from 0 on the first clock with reset_n high.

## Timing
- Read accepted in cycle N (read=1): readdata and readdatavalid=1 in cycle N+1. readdatavalid=0 otherwise.
- Back-to-back reads are sustained, one per cycle. There is no waitrequest; the slave is always ready.
- UPTIME_LO read returns the cnt value registered at edge N, i.e. before that cycle's increment.
- A following UPTIME_HI read returns the upper bits from the same instant, regardless of elapsed cycles.
- Writes take effect at the edge ending the write cycle; a read in the next cycle sees the new value.
- Counter increments on every edge after reset deassertion unless frozen, cleared or preloaded.

## Test plan
- Reset, then read addresses 0, 1 and 7 back-to-back: readdatavalid on 3 consecutive cycles with data 32'h58998DEB, TIMESTAMP and 0. readdata = 0 during reset.
- SCRATCH byte lanes: write 32'hAABBCCDD with byteenable 4'b1111, then 32'h11223344 with byteenable 4'b0101. Read returns 32'hAA22CC44.
- Snapshot coherence: preload HI = 1 and LO = 32'hFFFF_FFF0, read LO, wait 40 cycles, read HI. LO is near 32'hFFFF_FFF0+k and HI = 1, not 2; a second LO read followed by HI returns HI = 2.
- Wrap (COUNT_WIDTH=33): preload HI = 1 and LO = 32'hFFFF_FFFE, wait 3 cycles. STATUS reads 1 and the counter is small. Write STATUS = 1, then read: 0.
- FREEZE and CLEAR: write CONTROL = 2 and read LO twice 10 cycles apart: equal values. Write CONTROL = 3: LO reads 0 and stays 0. Write CONTROL = 0: counter resumes from 0.
- Simultaneous read+write to SCRATCH: old value returned, SCRATCH unchanged. Assert reset_n low during a pending read: no readdatavalid, all registers back to reset values.
